// File: rtl/display_pkg.sv
// Shared constants, state type and blanking helper for the multiplexed
// 7-segment display scan controller and its prescaler.
package display_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Shadow is zero-extended to eight digits, so "idx and every digit above it
    // are zero" reduces to a shift; digit 0 is never treated as a leading zero.
    function automatic logic is_lead_zero(input logic [31:0] shadow, input logic [2:0] idx);
        logic [31:0] upper;
        upper = shadow >> {idx, 2'b00};
        return (idx != 3'd0) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..SCAN_DIV-1 counter marking the first and last cycle of each
// slot; also serves as a generic timebase divider.
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic slot_start_o,
    output logic slot_end_o
);
    localparam int            CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap to zero on the last cycle of the slot.
    always_comb begin
        if (count_q == LAST) begin
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign slot_start_o = (count_q == {CW{1'b0}});
    assign slot_end_o   = (count_q == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of N_DIGITS BCD digits onto one shared decoder with
// a blank guard cycle per slot, leading-zero blanking and a frame marker.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  blank_all,
    output logic [3:0]            bcd_out,
    output logic [N_DIGITS-1:0]   dig_n,
    output logic                  frame_start
);
    localparam int                  IW       = $clog2(N_DIGITS);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{1'b1}};
    localparam logic [N_DIGITS-1:0] DIG_ONE  = N_DIGITS'(1);

    logic                  slot_start_s;
    logic                  slot_end_s;
    logic [4*N_DIGITS-1:0] shadow_q;
    logic [4*N_DIGITS-1:0] shadow_d;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_d;
    logic [3:0]            digit_s;
    logic [3:0]            code_d;
    scan_state_t           state_q;
    logic [3:0]            bcd_out_q;
    logic [N_DIGITS-1:0]   dig_n_q;
    logic                  frame_start_q;

    scan_prescaler #(
        .SCAN_DIV(SCAN_DIV)
    ) u_prescaler (
        .clk_i       (clk),
        .reset_i     (reset),
        .slot_start_o(slot_start_s),
        .slot_end_o  (slot_end_s)
    );

    // Shadow capture and digit index advance at each slot end.
    always_comb begin
        if (load) begin
            shadow_d = bcd_in;
        end else begin
            shadow_d = shadow_q;
        end
        if (slot_end_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Code for the upcoming slot, in blanking priority order.
    always_comb begin
        digit_s = shadow_q[4*idx_q +: 4];
        if (blank_all) begin
            code_d = BCD_BLANK;
        end else if (digit_s > 4'd9) begin
            code_d = BCD_BLANK;
        end else if (blank_lz && is_lead_zero(32'(shadow_q), 3'(idx_q))) begin
            code_d = BCD_BLANK;
        end else begin
            code_d = digit_s;
        end
    end

    // Shadow register and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= {(4*N_DIGITS){1'b0}};
            idx_q    <= {IW{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
        end
    end

    // Scan FSM with registered outputs; the code is latched only in GUARD so
    // a slot already being shown is never torn by load or blank changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= GUARD;
            bcd_out_q     <= BCD_BLANK;
            dig_n_q       <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            case (state_q)
                GUARD: begin
                    dig_n_q       <= DIG_OFF;
                    bcd_out_q     <= code_d;
                    frame_start_q <= slot_start_s && (idx_q == {IW{1'b0}});
                    state_q       <= SHOW;
                end
                SHOW: begin
                    dig_n_q       <= ~(DIG_ONE << idx_q);
                    frame_start_q <= 1'b0;
                    state_q       <= slot_end_s ? GUARD : SHOW;
                end
                default: begin
                    dig_n_q       <= DIG_OFF;
                    bcd_out_q     <= BCD_BLANK;
                    frame_start_q <= 1'b0;
                    state_q       <= GUARD;
                end
            endcase
        end
    end

    assign bcd_out     = bcd_out_q;
    assign dig_n       = dig_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: time-based reference model,
// per-cycle compare, directed literal checks and a randomized soak.
module tb_display_scan_ctrl;
    localparam int N  = 4;
    localparam int SD = 4;

    logic        clk;
    logic        reset;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_lz;
    logic        blank_all;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_n;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // Reference model: cycles since reset release plus the loaded value.
    int          m_t;
    int          m_idx;
    int          m_pos;
    logic [15:0] m_shadow;
    logic [3:0]  e_dig;
    logic [3:0]  e_bcd;
    logic        e_fs;
    logic [3:0]  prev_bcd;
    logic [3:0]  cap [4];

    display_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .blank_all  (blank_all),
        .bcd_out    (bcd_out),
        .dig_n      (dig_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] digit_code(input logic [15:0] sh, input int idx,
                                              input logic ba, input logic lz);
        int v;
        int p;
        int d;
        v = int'(sh);
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 16;
        d = (v / p) % 16;
        if (ba) return 4'hF;
        if (d > 9) return 4'hF;
        if (lz && idx != 0 && (v / p) == 0) return 4'hF;
        return 4'(d);
    endfunction

    assign m_idx = (m_t / SD) % N;
    assign m_pos = m_t % SD;

    always @(posedge clk) begin
        if (reset) begin
            m_t      <= 0;
            m_shadow <= 16'h0000;
            e_dig    <= 4'hF;
            e_bcd    <= 4'hF;
            e_fs     <= 1'b0;
        end else begin
            if (m_pos == 0) begin
                e_dig <= 4'hF;
                e_bcd <= digit_code(m_shadow, m_idx, blank_all, blank_lz);
                e_fs  <= (m_idx == 0);
            end else begin
                e_dig <= ~(4'b0001 << m_idx);
                e_fs  <= 1'b0;
            end
            if (load) m_shadow <= bcd_in;
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dig_n", 32'(dig_n), 32'(e_dig));
            check("bcd_out", 32'(bcd_out), 32'(e_bcd));
            check("frame_start", 32'(frame_start), 32'(e_fs));
            check("one_digit_max", 32'($countones(~dig_n) <= 1), 32'd1);
            if (bcd_out != prev_bcd) check("bcd_change_in_guard", 32'(dig_n), 32'hF);
            for (int i = 0; i < N; i++) begin
                if (dig_n == ~(4'b0001 << i)) cap[i] <= bcd_out;
            end
        end
        prev_bcd <= bcd_out;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [15:0] exp);
        tick(2 * N * SD);
        #1;
        for (int i = 0; i < N; i++) check(name, 32'(cap[i]), 32'(exp[4*i +: 4]));
    endtask

    task automatic sync_fs();
        int k;
        k = 0;
        tick(1);
        while (frame_start !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        check("sync_frame_start", 32'(frame_start), 32'd1);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; bcd_in = 16'h0000; blank_lz = 1'b0; blank_all = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_dig_n", 32'(dig_n), 32'hF);
        check("rst_bcd_out", 32'(bcd_out), 32'hF);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        reset = 1'b0;
        tick(1);
        check("first_guard_fs", 32'(frame_start), 32'd1);
        check("first_guard_dig", 32'(dig_n), 32'hF);
        check("first_guard_bcd", 32'(bcd_out), 32'h0);

        do_load(16'h1234);
        check_frame("scan_1234", 16'h1234);
        blank_lz = 1'b1;
        do_load(16'h0050);
        check_frame("lz_0050", 16'hFF50);
        do_load(16'h0000);
        check_frame("lz_0000", 16'hFFF0);
        blank_lz = 1'b0;
        do_load(16'h9A01);
        check_frame("invalid_9A01", 16'h9F01);
        blank_all = 1'b1;
        check_frame("blank_all", 16'hFFFF);
        blank_all = 1'b0;

        do_load(16'h2222);
        check_frame("val_2222", 16'h2222);
        sync_fs();
        tick(5);
        bcd_in = 16'h1111;
        load   = 1'b1;
        check("show_load_idx1_dig", 32'(dig_n), 32'hD);
        check("show_load_idx1_bcd", 32'(bcd_out), 32'h2);
        tick(1);
        load = 1'b0;
        tick(3);
        check("show_load_idx2_dig", 32'(dig_n), 32'hB);
        check("show_load_idx2_bcd", 32'(bcd_out), 32'h1);

        sync_fs();
        tick(3);
        bcd_in = 16'h3333;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
        check("guard_load_guard_dig", 32'(dig_n), 32'hF);
        check("guard_load_guard_bcd", 32'(bcd_out), 32'h1);
        tick(1);
        check("guard_load_show_bcd", 32'(bcd_out), 32'h1);
        tick(4);
        check("guard_load_next_dig", 32'(dig_n), 32'hB);
        check("guard_load_next_bcd", 32'(bcd_out), 32'h3);

        bcd_in = 16'h5555;
        load   = 1'b1;
        tick(1);
        bcd_in = 16'h6666;
        tick(1);
        load = 1'b0;
        check_frame("back_to_back", 16'h6666);

        sync_fs();
        tick(9);
        reset = 1'b1;
        tick(1);
        check("midrst_dig", 32'(dig_n), 32'hF);
        check("midrst_bcd", 32'(bcd_out), 32'hF);
        check("midrst_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
        tick(1);
        check("restart_fs", 32'(frame_start), 32'd1);
        check("restart_dig", 32'(dig_n), 32'hF);
        check("restart_bcd", 32'(bcd_out), 32'h0);
        check_frame("shadow_cleared", 16'h0000);

        for (int c = 0; c < 10000; c++) begin
            load   = ($urandom % 8) == 0;
            bcd_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if (($urandom % 64) == 0) blank_lz = ~blank_lz;
            if (($urandom % 97) == 0) blank_all = ~blank_all;
            reset  = ($urandom % 700) == 0;
            tick(1);
        end
        load  = 1'b0;
        reset = 1'b0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
